// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM states and
// result-vector bit positions.
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } cmp_state_t;

    localparam int RES_GT = 2;
    localparam int RES_EQ = 1;
    localparam int RES_LT = 0;

endpackage

// File: rtl/serial_magnitude_comparator_if.sv
// Start/done handshake, operands and three-way result of the serial comparator.
interface serial_magnitude_comparator_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             gt;
    logic             eq;
    logic             lt;

    modport master (output start, a, b, input busy, done, gt, eq, lt);
    modport slave  (input start, a, b, output busy, done, gt, eq, lt);
endinterface

// File: rtl/serial_magnitude_comparator_one_bit_comparator.sv
// One-bit comparator slice: greater / equal / less flags for a single bit pair.
module one_bit_comparator (
    input  logic A,
    input  logic B,
    output logic o1,
    output logic o2,
    output logic o3
);
    assign o1 = A & ~B;
    assign o2 = ~(A ^ B);
    assign o3 = ~A & B;
endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial unsigned magnitude comparator: scans MSB-first through a single
// one-bit slice and stops at the first differing bit.
module serial_magnitude_comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    serial_magnitude_comparator_if.slave  bus
);
    localparam int IDX_W = $clog2(WIDTH);

    cmp_state_t       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IDX_W-1:0] r_idx;
    logic             r_busy;
    logic             r_done;
    logic [2:0]       r_res;

    logic w_gt;
    logic w_eq;
    logic w_lt;

    // The slice always looks at the current MSBs; operands shift toward it.
    one_bit_comparator u_slice (
        .A  (r_a[WIDTH-1]),
        .B  (r_b[WIDTH-1]),
        .o1 (w_gt),
        .o2 (w_eq),
        .o3 (w_lt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_res   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_idx   <= IDX_W'(WIDTH - 1);
                        r_busy  <= 1'b1;
                        r_state <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (!w_eq) begin
                        r_res[RES_GT] <= w_gt;
                        r_res[RES_EQ] <= 1'b0;
                        r_res[RES_LT] <= w_lt;
                        r_done        <= 1'b1;
                        r_state       <= DONE;
                    end else if (r_idx == '0) begin
                        r_res[RES_GT] <= 1'b0;
                        r_res[RES_EQ] <= 1'b1;
                        r_res[RES_LT] <= 1'b0;
                        r_done        <= 1'b1;
                        r_state       <= DONE;
                    end else begin
                        r_a   <= r_a << 1;
                        r_b   <= r_b << 1;
                        r_idx <= r_idx - 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.gt   = r_res[RES_GT];
    assign bus.eq   = r_res[RES_EQ];
    assign bus.lt   = r_res[RES_LT];

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench for serial_magnitude_comparator: directed scenarios plus
// randomized operands against a whole-word reference model.
module tb_serial_magnitude_comparator;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    serial_magnitude_comparator_if #(.WIDTH(W)) bus();

    serial_magnitude_comparator #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [2:0] res;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         model_free = 0;
    int         bsy_lo = 0;
    int         bsy_hi = 0;
    logic [2:0] held = 3'b000;

    always @(posedge clk) cyc <= cyc + 1;

    // Number of COMPARE cycles: W - (highest differing bit), or W when equal.
    function automatic int lat(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x;
        x = a ^ b;
        if (x == '0) return W;
        for (int p = W - 1; p >= 0; p--)
            if (x[p]) return W - p;
        return W;
    endfunction

    function automatic logic [2:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b);
        int ia;
        int ib;
        ia = int'(a);
        ib = int'(b);
        return {ia > ib, ia == ib, ia < ib};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Acceptance model: a start seen while the model is idle is taken.
    always @(negedge clk) begin
        if (rst_n && bus.start && cyc >= model_free) begin
            int n;
            n = lat(bus.a, bus.b);
            q.push_back('{cyc + n + 1, ref_res(bus.a, bus.b)});
            bsy_lo     = cyc;
            bsy_hi     = cyc + n + 1;
            model_free = cyc + n + 2;
        end
    end

    // Monitor: busy every cycle, result and timing on each done.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", 32'(bus.busy), 32'(cyc > bsy_lo && cyc <= bsy_hi));
            if (bus.done) begin
                if (q.size() == 0) begin
                    chk("spurious_done", 32'(bus.done), 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("result", 32'({bus.gt, bus.eq, bus.lt}), 32'(e.res));
                    held = e.res;
                end
            end else begin
                if (q.size() != 0 && cyc > q[0].cyc) begin
                    chk("done_late", 32'(cyc), 32'(q[0].cyc));
                    held = q[0].res;
                    void'(q.pop_front());
                end
                chk("result_held", 32'({bus.gt, bus.eq, bus.lt}), 32'(held));
            end
        end
    end

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk);
        #1;
        bus.a = a;
        bus.b = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 64 && cyc < model_free; k++) @(posedge clk);
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({bus.busy, bus.done, bus.gt, bus.eq, bus.lt}), 32'd0);
        q.delete();
        held = 3'b000;
        bsy_lo = cyc;
        bsy_hi = cyc;
        model_free = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hold_outputs", 32'({bus.busy, bus.done, bus.gt, bus.eq, bus.lt}), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        #1;
        chk("power_on_reset", 32'({bus.busy, bus.done, bus.gt, bus.eq, bus.lt}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Equal operands: full-length scan.
        op(8'hA5, 8'hA5);
        wait_idle();
        // MSB differs: shortest scan.
        op(8'h80, 8'h7F);
        wait_idle();
        // Only LSB differs, then an immediate MSB decision.
        op(8'h12, 8'h13);
        wait_idle();
        op(8'hFF, 8'h00);
        wait_idle();

        // Second start while busy must be ignored.
        @(posedge clk);
        #1;
        bus.a = 8'h10; bus.b = 8'h20; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.a = 8'hFF; bus.b = 8'h00; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_idle();

        // Reset in the middle of an operation.
        op(8'h01, 8'h01);
        repeat (3) @(posedge clk);
        do_reset();
        op(8'h03, 8'h02);
        wait_idle();

        // Start held high: back-to-back operations.
        @(posedge clk);
        #1;
        bus.a = 8'h40; bus.b = 8'h00; bus.start = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
                default: rb = W'($urandom);
            endcase
            op(ra, rb);
            wait_idle();
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_magnitude_comparator.md
# serial_magnitude_comparator

Bit-serial WIDTH-bit unsigned magnitude comparator that reuses the team's one-bit comparator slice. It consumes the slice's per-bit greater/equal/less flags and scans the operands MSB-first, one bit per clock. It terminates at the first differing bit and reports a registered three-way result with a start/done handshake. It sits directly downstream of the one-bit slice and replaces a wide combinational compare where area matters more than latency.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; legal range WIDTH >= 2.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A (unsigned); captured on an accepted start.
- b  in  WIDTH  operand B (unsigned); captured on an accepted start.
- busy  out  1  high in COMPARE and DONE.
- done  out  1  one-cycle pulse; result valid from this cycle.
- gt  out  1  A > B, registered, held until the next completion.
- eq  out  1  A == B, registered, held until the next completion.
- lt  out  1  A < B, registered, held until the next completion.

## Operation
- States are IDLE, COMPARE and DONE, 2-bit encoding.
- IDLE:
  - start=1 loads a_q←a, b_q←b and idx←WIDTH-1, then moves to COMPARE.
  - start=0 stays in IDLE.
- COMPARE, one bit per cycle:
  - The slice sees a_q[WIDTH-1] and b_q[WIDTH-1].
  - If the slice equal flag is 0, latch {gt,eq,lt} from the slice flags and go to DONE.
  - Else if idx==0, latch gt=0, eq=1, lt=0 and go to DONE.
  - Otherwise shift a_q and b_q left by 1, decrement idx and stay in COMPARE.
- DONE: done=1 for this cycle only, then go to IDLE unconditionally.
- Result one-hot: after the first completion, exactly one of gt/eq/lt is high.
- Before the first completion, and after any reset, gt/eq/lt are all 0.
- start is ignored in COMPARE and DONE. There is no queueing. Operand changes while busy have no effect.
- idx is $clog2(WIDTH) bits wide and never underflows.
- No operand width mismatch is possible: both operands are WIDTH bits.

## Timing
- Reset: rst_n low forces the following immediately, independent of clk:
  - state=IDLE;
  - busy=0, done=0, gt=0, eq=0, lt=0;
  - a_q=0, b_q=0, idx=0.
- Reset release: normal operation begins on the first clk rising edge with rst_n high.
- Latency:
  - Let p be the highest differing bit position. The comparison takes n = WIDTH-p COMPARE cycles, or n = WIDTH if A==B.
  - done is high in the cycle beginning n+1 edges after the edge that sampled start.
  - gt/eq/lt change on the same edge that raises done.
- Bounds: minimum latency is 2 cycles (MSB differs). Maximum is WIDTH+1 cycles (equal operands, or difference only at the LSB).
- Back-to-back: if start is held high, a new operation is accepted in the IDLE cycle after DONE. Issue interval is n+2 cycles.
- Reset mid-operation aborts the operation. No done pulse is produced, and the previous result is cleared.
- busy is low only in IDLE. start is accepted iff busy==0 at the sampling edge.

## Structure
- Shared package comparator_pkg holds:
  - typedef cmp_state_t {IDLE, COMPARE, DONE};
  - result index localparams RES_GT, RES_EQ, RES_LT.
- One sub-module, one_bit_comparator, instantiated once.
  - Ports A, B, o1 (A>B), o2 (A==B), o3 (A<B).
  - Driven by the operand MSBs.
- Top-level RTL contains the FSM, shift registers, idx counter and result registers.

## Test plan
All scenarios use WIDTH=8.
- a=8'hA5, b=8'hA5, start for one cycle:
  - busy high for 9 cycles;
  - done high at cycle 9 after start;
  - gt=0, eq=1, lt=0.
- a=8'h80, b=8'h7F:
  - done at cycle 2;
  - gt=1, eq=0, lt=0.
- a=8'h12, b=8'h13 (LSB differs):
  - done at cycle 9;
  - lt=1, others 0;
  - then a=8'hFF, b=8'h00 gives done at cycle 2 with gt=1.
- Start a=8'h10, b=8'h20, then pulse start at cycle 1 with a=8'hFF, b=8'h00:
  - the second start is ignored;
  - a single done at cycle 4 with lt=1.
- Start a=8'h01, b=8'h01, assert rst_n low at cycle 5:
  - busy, done, gt, eq, lt go to 0 asynchronously, with no done pulse;
  - after release, a=8'h03, b=8'h02 completes with gt=1 at cycle 9.
- start held high with a=8'h40, b=8'h00:
  - done pulses every 4 cycles (cycles 3, 7, 11, …);
  - gt=1 throughout after the first pulse.
